// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: owns the PC, issues 8-byte pair reads on the
// instruction bus and buffers the returned words in a small FIFO for decode.
module instr_fetch_queue #(
  parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
  parameter int          QUEUE_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] bus_address,
  output logic        bus_read,
  output logic        bus_write,
  input  logic [31:0] bus_data_rd,
  input  logic [31:0] bus_data_rd_2,
  input  logic        bus_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {FETCH, DISCARD} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   discard_addr;
  logic [31:0]   q_inst [QUEUE_DEPTH];
  logic [31:0]   q_pc   [QUEUE_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] free_slots;
  logic          pop;
  logic          issue_ok;
  logic          complete;
  logic          stalled;
  logic          push_one;
  logic          push_two;
  logic [1:0]    push_n;

  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? q_inst[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? q_pc[rd_ptr]   : '0;
  assign bus_write  = 1'b0;

  assign pop        = inst_valid & inst_ready;
  assign free_slots = CW'(QUEUE_DEPTH) - count;
  // A pop this cycle frees one slot, so one free slot plus a pop is enough for a pair.
  assign issue_ok   = (free_slots >= CW'(2)) || (pop && (free_slots >= CW'(1)));
  assign complete   = bus_read & ~bus_stall;
  assign stalled    = bus_read & bus_stall;

  assign push_two = (state == FETCH) && complete && !redirect_valid && !fetch_pc[2];
  assign push_one = (state == FETCH) && complete && !redirect_valid &&  fetch_pc[2];
  assign push_n   = push_two ? 2'd2 : (push_one ? 2'd1 : 2'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (redirect_valid && stalled) state_nxt = DISCARD;
      DISCARD: if (!bus_stall)                state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    bus_read    = 1'b0;
    bus_address = {fetch_pc[31:3], 3'b000};
    if (!rst_n) begin
      bus_address = RESET_PC & ~32'h7;
    end else if (state == DISCARD) begin
      bus_read    = 1'b1;
      bus_address = discard_addr;
    end else begin
      bus_read    = issue_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      fetch_pc <= RESET_PC;
    else if (redirect_valid)
      fetch_pc <= redirect_pc;
    else if ((state == FETCH) && complete)
      fetch_pc <= fetch_pc + (fetch_pc[2] ? 32'd4 : 32'd8);
  end

  // The stalled request keeps its address on the bus until the slave releases it.
  always_ff @(posedge clk) begin
    if ((state == FETCH) && redirect_valid && stalled)
      discard_addr <= {fetch_pc[31:3], 3'b000};
  end

  always_ff @(posedge clk) begin
    if (!rst_n || redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_n);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push_n) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_one || push_two) begin
      q_inst[wr_ptr] <= push_one ? bus_data_rd_2 : bus_data_rd;
      q_pc[wr_ptr]   <= fetch_pc;
    end
    if (push_two) begin
      q_inst[wr_ptr + AW'(1)] <= bus_data_rd_2;
      q_pc[wr_ptr + AW'(1)]   <= fetch_pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: zero-wait memory model with driven
// stalls, checking bus requests and the decoded instruction stream.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_data_rd;
  logic [31:0] bus_data_rd_2;
  logic        bus_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch_queue #(.RESET_PC(32'hBFC0_0000), .QUEUE_DEPTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus_address   (bus_address),
    .bus_read      (bus_read),
    .bus_write     (bus_write),
    .bus_data_rd   (bus_data_rd),
    .bus_data_rd_2 (bus_data_rd_2),
    .bus_stall     (bus_stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  assign bus_data_rd   = mem_word(bus_address);
  assign bus_data_rd_2 = mem_word(bus_address + 32'd4);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    rst_n          = 1'b0;
    bus_stall      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = ready;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    int          nreads;
    int          n;
    logic [31:0] exp_pc;
    logic [31:0] pat;

    // Reset and first fetch
    rst_n = 1'b0; bus_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    cyc();
    #1;
    chk("rst_read", 32'(bus_read), 32'd0);
    chk("rst_addr", bus_address, 32'hBFC0_0000);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("c1_valid", 32'(inst_valid), 32'd0);
    chk("c1_inst", inst, 32'd0);
    chk("c1_pc", inst_pc, 32'd0);
    chk("c1_read", 32'(bus_read), 32'd1);
    chk("c1_addr", bus_address, 32'hBFC0_0000);
    chk("write_tied", 32'(bus_write), 32'd0);
    cyc(); #1;
    chk("c2_valid", 32'(inst_valid), 32'd1);
    chk("c2_pc", inst_pc, 32'hBFC0_0000);
    chk("c2_inst", inst, mem_word(32'hBFC0_0000));
    chk("c2_addr", bus_address, 32'hBFC0_0008);
    cyc(); #1;
    chk("c3_pc", inst_pc, 32'hBFC0_0004);
    chk("c3_inst", inst, mem_word(32'hBFC0_0004));
    cyc(); #1;
    chk("c4_pc", inst_pc, 32'hBFC0_0008);

    // Fill with decode stalled
    do_reset(1'b0);
    nreads = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus_read && !bus_stall) nreads++;
      cyc();
    end
    chk("fill_reads", 32'(nreads), 32'd4);
    #1;
    chk("full_noread", 32'(bus_read), 32'd0);
    inst_ready = 1'b1; #1;
    chk("pop1_noread", 32'(bus_read), 32'd0);
    chk("pop1_pc", inst_pc, 32'hBFC0_0000);
    cyc();
    inst_ready = 1'b0; #1;
    chk("cnt7_noread", 32'(bus_read), 32'd0);
    chk("cnt7_pc", inst_pc, 32'hBFC0_0004);
    inst_ready = 1'b1; #1;
    chk("pop2_read", 32'(bus_read), 32'd1);
    chk("pop2_addr", bus_address, 32'hBFC0_0020);
    cyc();

    // Redirect to an odd-word target while idle
    inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0014;
    cyc();
    redirect_valid = 1'b0; #1;
    chk("rd_valid0", 32'(inst_valid), 32'd0);
    chk("rd_read", 32'(bus_read), 32'd1);
    chk("rd_addr", bus_address, 32'h8000_0010);
    cyc(); #1;
    chk("rd_hvalid", 32'(inst_valid), 32'd1);
    chk("rd_hpc", inst_pc, 32'h8000_0014);
    chk("rd_hinst", inst, mem_word(32'h8000_0014));
    chk("rd_next", bus_address, 32'h8000_0018);
    inst_ready = 1'b1;
    cyc(); #1;
    chk("rd_pc2", inst_pc, 32'h8000_0018);
    inst_ready = 1'b0;

    // Redirect during a stalled request
    do_reset(1'b0);
    cyc();
    cyc();
    bus_stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_1000; #1;
    chk("st_addr0", bus_address, 32'hBFC0_0010);
    chk("st_read0", 32'(bus_read), 32'd1);
    cyc();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus_stall = 1'b0;
      #1;
      chk("st_hold_addr", bus_address, 32'hBFC0_0010);
      chk("st_hold_read", 32'(bus_read), 32'd1);
      chk("st_no_stale", 32'(inst_valid), 32'd0);
      cyc();
    end
    #1;
    chk("st_new_addr", bus_address, 32'h8000_1000);
    chk("st_new_read", 32'(bus_read), 32'd1);
    chk("st_new_valid", 32'(inst_valid), 32'd0);
    cyc(); #1;
    chk("st_hvalid", 32'(inst_valid), 32'd1);
    chk("st_hpc", inst_pc, 32'h8000_1000);
    chk("st_hinst", inst, mem_word(32'h8000_1000));

    // Stream 20 words through the FIFO with an irregular decode pattern
    do_reset(1'b0);
    pat    = 32'b1011_0010_1110_0101_0011_1101_1000_1101;
    exp_pc = 32'hBFC0_0000;
    n      = 0;
    for (int c = 0; c < 200 && n < 20; c++) begin
      inst_ready = pat[c % 32];
      #1;
      if (inst_valid && inst_ready) begin
        chk("stream_pc", inst_pc, exp_pc);
        chk("stream_inst", inst, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n++;
      end
      cyc();
    end
    chk("stream_count", 32'(n), 32'd20);

    // Reset while a request is stalled with three words queued
    do_reset(1'b0);
    cyc();
    cyc();
    inst_ready = 1'b1; bus_stall = 1'b1; #1;
    chk("mr_read", 32'(bus_read), 32'd1);
    chk("mr_addr", bus_address, 32'hBFC0_0010);
    cyc();
    inst_ready = 1'b0; rst_n = 1'b0; #1;
    chk("mr_rst_read", 32'(bus_read), 32'd0);
    chk("mr_rst_addr", bus_address, 32'hBFC0_0000);
    chk("mr_q_pc", inst_pc, 32'hBFC0_0004);
    cyc();
    rst_n = 1'b1; bus_stall = 1'b0; #1;
    chk("mr_valid", 32'(inst_valid), 32'd0);
    chk("mr_addr2", bus_address, 32'hBFC0_0000);
    chk("mr_read2", 32'(bus_read), 32'd1);
    cyc(); #1;
    chk("mr_hpc", inst_pc, 32'hBFC0_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
